// File: rtl/timing_control.sv
// Sequence counter, opcode decode and execute-strobe generator for the basic computer.
// Steps instructions through T0..T6 and drives PC, AC and E-flag strobes plus run/halt.
module timing_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        ac_zero,
    input  logic        ac_sign,
    input  logic        e_in,
    input  logic        dr_zero,
    output logic [7:0]  sc_t,
    output logic [7:0]  d,
    output logic        i_flag,
    output logic        run,
    output logic        pc_inc,
    output logic        ac_ld,
    output logic [2:0]  ac_op,
    output logic        e_ld,
    output logic        e_clr,
    output logic [1:0]  e_sel
);

    logic [2:0] sc;
    logic [2:0] sc_next;
    logic       run_next;
    logic       sc_clr;
    logic       halt;
    logic       rr;
    logic       skip;

    // One-hot expansion of a 3-bit index.
    function automatic logic [7:0] onehot3(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Sequence counter and run flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc  <= 3'd0;
            run <= 1'b1;
        end else begin
            sc  <= sc_next;
            run <= run_next;
        end
    end

    // Opcode and indirect bit are captured on the edge that ends T2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d      <= 8'h00;
            i_flag <= 1'b0;
        end else if (sc_t[2]) begin
            d      <= onehot3(ir[14:12]);
            i_flag <= ir[15];
        end else begin
            d      <= d;
            i_flag <= i_flag;
        end
    end

    // Next counter value and run state; start overrides a same-cycle HLT.
    always_comb begin
        sc_next  = 3'd0;
        run_next = run;
        if (!run) begin
            sc_next  = 3'd0;
            run_next = start;
        end else begin
            sc_next  = sc_clr ? 3'd0 : sc + 3'd1;
            run_next = start | ~halt;
        end
    end

    // Timing decode and instruction-end detection.
    always_comb begin
        sc_t   = run ? onehot3(sc) : 8'h00;
        rr     = d[7] & ~i_flag & sc_t[3];
        sc_clr = (sc_t[5] & (d[0] | d[1] | d[2] | d[5]))
               | (sc_t[4] & (d[3] | d[4]))
               | (sc_t[6] & d[6])
               | (sc_t[3] & d[7]);
        halt   = rr & ir[0];
        skip   = (ir[4] & ~ac_sign) | (ir[3] & ac_sign)
               | (ir[2] & ac_zero) | (ir[1] & ~e_in);
    end

    // Execute strobes; all are gated through sc_t so they vanish while halted.
    always_comb begin
        pc_inc = sc_t[1] | (sc_t[6] & d[6] & dr_zero) | (rr & skip);
        ac_ld  = (sc_t[5] & (d[0] | d[1] | d[2]))
               | (rr & (ir[11] | ir[9] | ir[7] | ir[6] | ir[5]));
        e_ld   = (sc_t[5] & d[1]) | (rr & (ir[10] | ir[8] | ir[7] | ir[6]));
        e_clr  = rr & ir[10];

        if (sc_t[5] & d[1]) begin
            ac_op = 3'd1;
        end else if (sc_t[5] & d[2]) begin
            ac_op = 3'd2;
        end else if (rr & ir[11]) begin
            ac_op = 3'd3;
        end else if (rr & ir[9]) begin
            ac_op = 3'd4;
        end else if (rr & ir[7]) begin
            ac_op = 3'd5;
        end else if (rr & ir[6]) begin
            ac_op = 3'd6;
        end else if (rr & ir[5]) begin
            ac_op = 3'd7;
        end else begin
            ac_op = 3'd0;
        end

        // Rotates take E from the bit shifted out; they beat complement.
        if (rr & ir[7]) begin
            e_sel = 2'd2;
        end else if (rr & ir[6]) begin
            e_sel = 2'd3;
        end else if (rr & ir[8]) begin
            e_sel = 2'd1;
        end else begin
            e_sel = 2'd0;
        end
    end

endmodule
